// File: rtl/fakeram7_dp_arbiter_if.sv
// Requester-side bundle for the fakeram7 dual-port arbiter.
// Flattened per-requester lanes; requester i owns slice i.
interface fakeram7_dp_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*BITS-1:0]       req_wdata;
  logic [NUM_REQ*BITS-1:0]       req_wmask;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*BITS-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/fakeram7_dp_arbiter.sv
// Round-robin sharing of one fakeram7 dual-port macro.
// Up to two grants per cycle (A then B), 1-cycle read return.
module fakeram7_dp_arbiter #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fakeram7_dp_arbiter_if.slave  bus,
  output logic                  ram_ce,
  output logic [ADDR_WIDTH-1:0] ram_addr_A,
  output logic [ADDR_WIDTH-1:0] ram_addr_B,
  output logic                  ram_we_A,
  output logic                  ram_we_B,
  output logic [BITS-1:0]       ram_wd_A,
  output logic [BITS-1:0]       ram_wd_B,
  output logic [BITS-1:0]       ram_wmask_A,
  output logic [BITS-1:0]       ram_wmask_B,
  input  logic [BITS-1:0]       ram_rd_A,
  input  logic [BITS-1:0]       ram_rd_B
);
  localparam int AW = (WORD_DEPTH > 1) ? ADDR_WIDTH : 1;
  localparam int N  = NUM_REQ;
  localparam int PW = $clog2(N);

  logic [PW-1:0]     rr_q, rr_d;
  logic [N-1:0]      rd_a_q, rd_a_d;
  logic [N-1:0]      rd_b_q, rd_b_d;
  logic [N*BITS-1:0] hold_q;

  logic [N-1:0]      g_a, c_b, g_b;
  logic [AW-1:0]     a_addr, b_addr;
  logic              a_we, b_we, confl;
  logic [BITS-1:0]   a_wd, b_wd, a_wm, b_wm;
  logic [PW-1:0]     ia, ib, last;

  // Pure AND/OR scan so an X on a valid bit reaches ce/we.
  always_comb begin : scan
    logic s1, s2;
    int   j;
    s1  = 1'b0;
    s2  = 1'b0;
    g_a = '0;
    c_b = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j -= N;
      g_a[j] = bus.req_valid[j] & ~s1;
      c_b[j] = bus.req_valid[j] & s1 & ~s2;
      s2 = s2 | (s1 & bus.req_valid[j]);
      s1 = s1 | bus.req_valid[j];
    end
  end

  always_comb begin
    a_addr = '0; a_we = 1'b0;
    a_wd   = '0; a_wm = '0;
    b_addr = '0; b_we = 1'b0;
    b_wd   = '0; b_wm = '0;
    ia     = '0; ib   = '0;
    for (int i = 0; i < N; i++) begin
      a_addr |= bus.req_addr[i*AW +: AW] & {AW{g_a[i]}};
      a_we   |= bus.req_we[i] & g_a[i];
      a_wd   |= bus.req_wdata[i*BITS +: BITS] & {BITS{g_a[i]}};
      a_wm   |= bus.req_wmask[i*BITS +: BITS] & {BITS{g_a[i]}};
      b_addr |= bus.req_addr[i*AW +: AW] & {AW{c_b[i]}};
      b_we   |= bus.req_we[i] & c_b[i];
      b_wd   |= bus.req_wdata[i*BITS +: BITS] & {BITS{c_b[i]}};
      b_wm   |= bus.req_wmask[i*BITS +: BITS] & {BITS{c_b[i]}};
      ia     |= PW'(i) & {PW{g_a[i]}};
      ib     |= PW'(i) & {PW{c_b[i]}};
    end
  end

  // B never skips ahead: a conflicting candidate just idles port B.
  assign confl = (a_addr == b_addr) & (a_we | b_we);
  assign g_b   = c_b & {N{~confl}};

  assign bus.req_ready = g_a | g_b;
  assign ram_ce        = |g_a;
  assign ram_addr_A    = a_addr;
  assign ram_we_A      = a_we;
  assign ram_wd_A      = a_wd;
  assign ram_wmask_A   = a_wm;
  assign ram_addr_B    = b_addr & {AW{~confl}};
  assign ram_we_B      = b_we & ~confl;
  assign ram_wd_B      = b_wd & {BITS{~confl}};
  assign ram_wmask_B   = b_wm & {BITS{~confl}};

  assign last = (|g_b) ? ib : ia;
  assign rr_d = ram_ce
              ? ((last == PW'(N-1)) ? '0 : last + 1'b1)
              : rr_q;

  assign rd_a_d = g_a & {N{~a_we}};
  assign rd_b_d = g_b & {N{~ram_we_B}};

  assign bus.rsp_valid = rd_a_q | rd_b_q;

  always_comb begin
    bus.rsp_rdata = hold_q;
    for (int i = 0; i < N; i++) begin
      if (rd_a_q[i])
        bus.rsp_rdata[i*BITS +: BITS] = ram_rd_A;
      else if (rd_b_q[i])
        bus.rsp_rdata[i*BITS +: BITS] = ram_rd_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      hold_q <= '0;
    end else begin
      rr_q   <= rr_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      hold_q <= bus.rsp_rdata;
    end
  end
endmodule

// File: tb/tb_fakeram7_dp_arbiter.sv
// Directed bench for fakeram7_dp_arbiter with a behavioural
// dual-port macro model (1-cycle read, bit-masked write).
module tb_fakeram7_dp_arbiter;
  localparam int N  = 4;
  localparam int B  = 32;
  localparam int AW = 9;

  logic clk, rst_n;
  logic          ram_ce;
  logic [AW-1:0] ram_addr_A, ram_addr_B;
  logic          ram_we_A, ram_we_B;
  logic [B-1:0]  ram_wd_A, ram_wd_B;
  logic [B-1:0]  ram_wmask_A, ram_wmask_B;
  logic [B-1:0]  ram_rd_A, ram_rd_B;

  int checks = 0;
  int errors = 0;

  fakeram7_dp_arbiter_if #(.NUM_REQ(N), .BITS(B), .ADDR_WIDTH(AW)) bus ();

  fakeram7_dp_arbiter #(
    .BITS(B), .WORD_DEPTH(512), .ADDR_WIDTH(AW), .NUM_REQ(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_ce(ram_ce),
    .ram_addr_A(ram_addr_A), .ram_addr_B(ram_addr_B),
    .ram_we_A(ram_we_A), .ram_we_B(ram_we_B),
    .ram_wd_A(ram_wd_A), .ram_wd_B(ram_wd_B),
    .ram_wmask_A(ram_wmask_A), .ram_wmask_B(ram_wmask_B),
    .ram_rd_A(ram_rd_A), .ram_rd_B(ram_rd_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [B-1:0] mem [512];

  always @(posedge clk) begin
    if (ram_ce === 1'b1) begin
      if (ram_we_A)
        mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_wmask_A)
                         | (ram_wd_A & ram_wmask_A);
      else
        ram_rd_A <= mem[ram_addr_A];
      if (ram_we_B)
        mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_wmask_B)
                         | (ram_wd_B & ram_wmask_B);
      else
        ram_rd_B <= mem[ram_addr_B];
    end
  end

  task automatic clr();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
  endtask

  task automatic set(input int i, input logic we,
                     input logic [AW-1:0] a,
                     input logic [B-1:0] d, input logic [B-1:0] m);
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*B +: B]   = d;
    bus.req_wmask[i*B +: B]   = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.rsp_valid !== 4'b0 || ram_ce !== 1'b0 ||
        bus.req_ready !== 4'b0 || ram_we_A !== 1'b0 ||
        ram_we_B !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rsp_valid=%b ce=%b ready=%b weA=%b weB=%b want 0",
               bus.rsp_valid, ram_ce, bus.req_ready, ram_we_A, ram_we_B);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set(2, 1'b0, 9'h1F0, '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL reset_pre_ready: got %b want 0100", bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0100) begin
      errors++;
      $display("FAIL reset_inflight: got %b want 0100", bus.rsp_valid);
    end
    rst_n = 1'b0;
    clr();
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0 || ram_ce !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rsp_valid=%b ce=%b want 0 0",
               bus.rsp_valid, ram_ce);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_no_rsp: got %b want 0000", bus.rsp_valid);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) set(i, 1'b0, AW'(i), '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0011) begin
      errors++;
      $display("FAIL reset_rr: ready=%b want 0011", bus.req_ready);
    end
    clr();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set(0, 1'b1, 9'h1F0, 32'h11223344, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || ram_we_A !== 1'b1 ||
        ram_addr_A !== 9'h1F0 || ram_we_B !== 1'b0) begin
      errors++;
      $display("FAIL wr_pre: ready=%b weA=%b addrA=%h weB=%b want 0001 1 1f0 0",
               bus.req_ready, ram_we_A, ram_addr_A, ram_we_B);
    end
    @(negedge clk);
    set(0, 1'b1, 9'h1F0, 32'hDEADBEEF, 32'hFFFF0000);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || ram_wmask_A !== 32'hFFFF0000 ||
        ram_wd_A !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_masked: ready=%b wd=%h wm=%h want 0001 deadbeef ffff0000",
               bus.req_ready, ram_wd_A, ram_wmask_A);
    end
    @(negedge clk);
    set(0, 1'b0, 9'h1F0, '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || ram_we_A !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: ready=%b weA=%b want 0001 0",
               bus.req_ready, ram_we_A);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0001 ||
        bus.rsp_rdata[31:0] !== 32'hDEAD3344) begin
      errors++;
      $display("FAIL rd_data: valid=%b data=%h want 0001 dead3344",
               bus.rsp_valid, bus.rsp_rdata[31:0]);
    end
    @(negedge clk);
    clr();
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0 ||
        bus.rsp_rdata[31:0] !== 32'hDEAD3344) begin
      errors++;
      $display("FAIL rd_hold: valid=%b data=%h want 0000 dead3344",
               bus.rsp_valid, bus.rsp_rdata[31:0]);
    end
  endtask

  task automatic test_dual();
    do_reset();
    @(negedge clk);
    set(1, 1'b1, 9'd5, 32'h5555_5555, 32'hFFFF_FFFF);
    set(3, 1'b1, 9'd9, 32'h9999_9999, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1010 || ram_we_B !== 1'b1 ||
        ram_addr_B !== 9'd9) begin
      errors++;
      $display("FAIL dual_wr: ready=%b weB=%b addrB=%0d want 1010 1 9",
               bus.req_ready, ram_we_B, ram_addr_B);
    end
    do_reset();
    @(negedge clk);
    set(1, 1'b0, 9'd5, '0, '0);
    set(3, 1'b0, 9'd9, '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1010 || ram_addr_A !== 9'd5 ||
        ram_addr_B !== 9'd9) begin
      errors++;
      $display("FAIL dual_rd: ready=%b addrA=%0d addrB=%0d want 1010 5 9",
               bus.req_ready, ram_addr_A, ram_addr_B);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b1010 ||
        bus.rsp_rdata[63:32] !== 32'h5555_5555 ||
        bus.rsp_rdata[127:96] !== 32'h9999_9999) begin
      errors++;
      $display("FAIL dual_rsp: valid=%b d1=%h d3=%h want 1010 55555555 99999999",
               bus.rsp_valid, bus.rsp_rdata[63:32], bus.rsp_rdata[127:96]);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    set(0, 1'b1, 9'h10, 32'hCAFEF00D, 32'hFFFF_FFFF);
    set(1, 1'b0, 9'h10, '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || ram_we_B !== 1'b0 ||
        ram_ce !== 1'b1 || ram_addr_B !== 9'h0) begin
      errors++;
      $display("FAIL confl_grant: ready=%b weB=%b ce=%b addrB=%h want 0001 0 1 0",
               bus.req_ready, ram_we_B, ram_ce, ram_addr_B);
    end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010 || ram_addr_A !== 9'h10) begin
      errors++;
      $display("FAIL confl_next: ready=%b addrA=%h want 0010 10",
               bus.req_ready, ram_addr_A);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0010 ||
        bus.rsp_rdata[63:32] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL confl_rsp: valid=%b data=%h want 0010 cafef00d",
               bus.rsp_valid, bus.rsp_rdata[63:32]);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_fairness();
    int cnt [N];
    int lastg [N];
    int maxw;
    logic [N-1:0] exp;
    maxw = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      lastg[i] = -1;
    end
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set(i, 1'b0, AW'(32 + i), '0, '0);
    #1;
    for (int c = 0; c < 8; c++) begin
      exp = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++;
      if (bus.req_ready !== exp) begin
        errors++;
        $display("FAIL fair_cycle%0d: ready=%b want %b", c, bus.req_ready, exp);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          cnt[i]++;
          if (c - lastg[i] > maxw) maxw = c - lastg[i];
          lastg[i] = c;
        end
      end
      @(negedge clk); #1;
    end
    clr();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 4) begin
        errors++;
        $display("FAIL fair_count%0d: got %0d want 4", i, cnt[i]);
      end
    end
    checks++;
    if (maxw > N) begin
      errors++;
      $display("FAIL fair_wait: got %0d want <= %0d", maxw, N);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    do_reset();
    @(negedge clk);
    set(0, 1'b1, 9'h30, 32'h0, 32'h0);
    @(negedge clk);
    clr();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ram_ce !== 1'b0 || bus.rsp_valid !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) set(i, 1'b0, AW'(i), '0, '0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0110) begin
      errors++;
      $display("FAIL idle_rr: ready=%b want 0110", bus.req_ready);
    end
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    test_reset();
    test_write_read();
    test_dual();
    test_conflict();
    test_fairness();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
